// File: rtl/mux5.sv
// ----------------------------------------------------------------------------
// mux5 -- 5:1 data-path select mux with a remembered last-valid select.
//
// A valid select (0..4) routes the chosen input straight to y with no
// latency. An invalid select (5..7) falls back to the input chosen by the
// last valid select. That select is captured in sel_q on each rising clk edge.
// The output path is purely combinational; sel_q is the only state.
//
// Ports
//   clk    in   1      system clock, sel_q updates on the rising edge
//   reset  in   1      synchronous active-high reset, clears sel_q to 0
//   d0..d4 in   WIDTH  data inputs for selects 0..4
//   s      in   3      select
//   y      out  WIDTH  selected data
// ----------------------------------------------------------------------------
module mux5 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    input  logic [WIDTH-1:0] d4,
    input  logic [2:0]       s,
    output logic [WIDTH-1:0] y
);

    logic [2:0] sel_q;
    logic [2:0] sel_d;
    logic [2:0] sel_eff;

    // Only a valid select is remembered; anything else (including X/Z)
    // keeps the previous capture.
    always_comb begin
        sel_d = sel_q;
        case (s)
            3'd0, 3'd1, 3'd2, 3'd3, 3'd4: sel_d = s;
            default:                      sel_d = sel_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sel_q <= 3'd0;
        end else begin
            sel_q <= sel_d;
        end
    end

    // A valid s wins immediately, independent of sel_q, so the live select
    // takes effect in the same cycle rather than one edge later.
    always_comb begin
        sel_eff = sel_q;
        case (s)
            3'd0, 3'd1, 3'd2, 3'd3, 3'd4: sel_eff = s;
            default:                      sel_eff = sel_q;
        endcase
    end

    always_comb begin
        y = d0;
        case (sel_eff)
            3'd0:    y = d0;
            3'd1:    y = d1;
            3'd2:    y = d2;
            3'd3:    y = d3;
            3'd4:    y = d4;
            default: y = d0;
        endcase
    end

endmodule

// File: tb/tb_mux5.sv
module tb_mux5;

    localparam int WIDTH = 32;

    logic                       clk;
    logic                       reset;
    logic [4:0][WIDTH-1:0]      dvec;
    logic [2:0]                 s;
    logic [WIDTH-1:0]           y;

    int errors = 0;
    int checks = 0;

    // Reference state: index of the last valid select seen at a clock edge.
    int last_valid;

    mux5 #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .d0    (dvec[0]),
        .d1    (dvec[1]),
        .d2    (dvec[2]),
        .d3    (dvec[3]),
        .d4    (dvec[4]),
        .s     (s),
        .y     (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic                  rst;
        logic [2:0]            sel;
        logic [4:0][WIDTH-1:0] d;
        logic [WIDTH-1:0]      exp_y;
        bit                    edge_after;
        string                 name;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [WIDTH-1:0] model_y();
        int idx;
        idx = (int'(s) <= 4) ? int'(s) : last_valid;
        return dvec[idx];
    endfunction

    // One rising edge; the model updates from the inputs present at the edge,
    // and control returns on the falling edge so checks sit away from posedge.
    task automatic tick();
        @(posedge clk);
        if (reset) last_valid = 0;
        else if (int'(s) <= 4) last_valid = int'(s);
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [WIDTH-1:0] exp);
        checks++;
        if (y !== exp) begin
            errors++;
            $display("FAIL %s: y=%0d expected %0d (s=%0d reset=%0b)", name, y, exp, s, reset);
        end
    endtask

    function automatic logic [4:0][WIDTH-1:0] mkd(input int a, input int b, input int c,
                                                  input int e, input int f);
        logic [4:0][WIDTH-1:0] r;
        r[0] = WIDTH'(a); r[1] = WIDTH'(b); r[2] = WIDTH'(c); r[3] = WIDTH'(e); r[4] = WIDTH'(f);
        return r;
    endfunction

    task automatic add(input logic rst, input int sel, input logic [4:0][WIDTH-1:0] d,
                       input int exp, input bit edge_after, input string name);
        vec_t v;
        v.rst = rst; v.sel = 3'(sel); v.d = d; v.exp_y = WIDTH'(exp);
        v.edge_after = edge_after; v.name = name;
        vecs.push_back(v);
    endtask

    initial begin
        logic [4:0][WIDTH-1:0] base;
        base = mkd(1, 2, 4, 8, 16);
        last_valid = 0;

        // Initial reset, then an invalid select must show d0.
        add(1, 0, base, 1, 1, "init_reset");
        add(0, 7, base, 1, 0, "post_reset_invalid");
        // Step 1: walk valid selects, capturing each.
        add(0, 0, base, 1,  1, "s0");
        add(0, 1, base, 2,  1, "s1");
        add(0, 2, base, 4,  1, "s2");
        add(0, 3, base, 8,  1, "s3");
        add(0, 4, base, 16, 1, "s4");
        // Step 2: live data change on the selected input, no clock.
        add(0, 4, mkd(1, 2, 4, 8, 32), 32, 0, "d4_live");
        // Step 3: invalid selects hold sel_q = 4.
        add(0, 5, mkd(1, 2, 4, 8, 32), 32, 1, "hold_s5");
        add(0, 6, mkd(1, 2, 4, 8, 32), 32, 1, "hold_s6");
        add(0, 7, mkd(1, 2, 4, 8, 32), 32, 1, "hold_s7");
        add(0, 7, mkd(1, 2, 4, 8, 32), 32, 0, "hold_after_s7");
        // Step 4: held select tracks live data; unselected d0 does not matter.
        add(0, 7, mkd(1, 2, 4, 8, 64),  64, 0, "held_d4_live");
        add(0, 7, mkd(99, 2, 4, 8, 64), 64, 0, "held_d0_ignored");
        // Step 5: reset with invalid s; y uses old sel_q until the edge.
        add(1, 6, mkd(1, 2, 4, 8, 64), 64, 1, "reset_s6_pre");
        add(0, 6, mkd(1, 2, 4, 8, 64), 1,  0, "reset_s6_post");
        // Step 6: reset beats a valid s at the same edge.
        add(1, 3, mkd(1, 2, 4, 8, 64), 8, 1, "reset_s3");
        add(0, 3, mkd(1, 2, 4, 8, 64), 8, 0, "after_reset_s3");
        add(0, 5, mkd(1, 2, 4, 8, 64), 1, 0, "reset_won");
        // Valid then invalid with no edge between uses the older sel_q.
        add(0, 2, mkd(1, 2, 4, 8, 64), 4, 0, "valid_no_edge");
        add(0, 5, mkd(1, 2, 4, 8, 64), 1, 0, "invalid_uses_old");
        add(0, 2, mkd(1, 2, 4, 8, 64), 4, 1, "capture_2");
        add(0, 6, mkd(1, 2, 4, 8, 64), 4, 0, "held_2");

        reset = 1'b1;
        s     = 3'd0;
        dvec  = base;
        @(negedge clk);

        foreach (vecs[i]) begin
            reset = vecs[i].rst;
            s     = vecs[i].sel;
            dvec  = vecs[i].d;
            #1;
            check(vecs[i].name, vecs[i].exp_y);
            if (vecs[i].edge_after) tick();
        end

        // Randomized phase against the reference model.
        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 15) == 0);
            s     = 3'($urandom_range(0, 7));
            for (int k = 0; k < 5; k++) dvec[k] = $urandom();
            #1;
            check("random", model_y());
            if ($urandom_range(0, 3) != 0) tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
